// File: rtl/pc_unit_if.sv
// Handshake/bus bundle between the fetch-stage controller and pc_unit.
// master drives mode/target inputs; slave (pc_unit) drives the PC and RAS status.
interface pc_unit_if #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              stall;
    logic [2:0]        pc_sel;
    logic              cond;
    logic [ADDR_W-1:0] reg_data;
    logic [ADDR_W-1:0] jump_imm;
    logic [ADDR_W-1:0] branch_imm;
    logic              flags_clr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    modport master (
        output stall, pc_sel, cond, reg_data, jump_imm, branch_imm, flags_clr,
        input  pc, pc_plus1, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, pc_sel, cond, reg_data, jump_imm, branch_imm, flags_clr,
        output pc, pc_plus1, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Registered program counter with next-PC mode select, stall and sticky error flags.
// Define PCU_RAS_EN to build the circular return-address stack (call/return modes).
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] OS_VECTOR = ADDR_W'(524),
    parameter int                RAS_DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset,
    pc_unit_if.slave bus
);
    typedef enum logic {RESET_HOLD, RUN} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus1;
    logic              advance;

    assign pc_plus1     = pc_reg + ADDR_W'(1);
    assign bus.pc       = pc_reg;
    assign bus.pc_plus1 = pc_plus1;

    // PC and RAS only move once the post-reset hold cycle has passed.
    assign advance = (state_reg == RUN) && !bus.stall;

`ifdef PCU_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              push;
    logic              pop;
    logic              ras_full;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;

    // ptr_reg points at the next free slot; when full that slot is the oldest entry.
    assign ras_full          = (count_reg == CNT_W'(RAS_DEPTH));
    assign ras_empty         = (count_reg == '0);
    assign ras_top           = ras_mem[ptr_reg - PTR_W'(1)];
    assign bus.ras_count     = count_reg;
    assign bus.ras_overflow  = overflow_reg;
    assign bus.ras_underflow = underflow_reg;
`else
    assign bus.ras_count     = '0;
    assign bus.ras_overflow  = 1'b0;
    assign bus.ras_underflow = 1'b0;
`endif

    always_comb begin
        pc_next = pc_plus1;
`ifdef PCU_RAS_EN
        push = 1'b0;
        pop  = 1'b0;
`endif
        case (bus.pc_sel)
            3'd1: pc_next = bus.reg_data;
            3'd2: pc_next = bus.jump_imm;
            3'd3: pc_next = bus.cond ? bus.branch_imm : pc_plus1;
            3'd4: pc_next = OS_VECTOR;
`ifdef PCU_RAS_EN
            3'd5: begin
                pc_next = bus.jump_imm;
                push    = 1'b1;
            end
            3'd6: begin
                pc_next = ras_empty ? OS_VECTOR : ras_top;
                pop     = 1'b1;
            end
`else
            3'd5: pc_next = bus.jump_imm;
            3'd6: pc_next = bus.reg_data;
`endif
            default: pc_next = pc_plus1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= RESET_HOLD;
            pc_reg    <= RESET_PC;
        end else if (state_reg == RESET_HOLD) begin
            state_reg <= RUN;
        end else if (advance) begin
            pc_reg <= pc_next;
        end
    end

`ifdef PCU_RAS_EN
    // Storage has no reset so it can map onto plain RAM.
    always_ff @(posedge clock) begin
        if (reset && advance && push)
            ras_mem[ptr_reg] <= pc_plus1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (bus.flags_clr) begin
                overflow_reg  <= 1'b0;
                underflow_reg <= 1'b0;
            end
            // A new error in the same cycle as flags_clr wins by being assigned last.
            if (advance && push) begin
                ptr_reg <= ptr_reg + PTR_W'(1);
                if (ras_full)
                    overflow_reg <= 1'b1;
                else
                    count_reg <= count_reg + CNT_W'(1);
            end
            if (advance && pop) begin
                if (ras_empty) begin
                    underflow_reg <= 1'b1;
                end else begin
                    ptr_reg   <= ptr_reg - PTR_W'(1);
                    count_reg <= count_reg - CNT_W'(1);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; expectations adapt to whether PCU_RAS_EN is built.
module tb_pc_unit;
`ifdef PCU_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pc_unit_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();

    pc_unit #(
        .ADDR_W(32), .RESET_PC(32'd0), .OS_VECTOR(32'd524), .RAS_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("step %-14s pc=%0d count=%0d ovf=%0b unf=%0b", tag, bus.pc,
                 bus.ras_count, bus.ras_overflow, bus.ras_underflow);
    endtask

    task automatic go(input logic [2:0] sel, input logic [31:0] tgt);
        bus.pc_sel   = sel;
        bus.jump_imm = tgt;
        tick();
    endtask

    initial begin
        bus.stall = 1'b0; bus.pc_sel = 3'd0; bus.cond = 1'b0; bus.flags_clr = 1'b0;
        bus.reg_data = '0; bus.jump_imm = '0; bus.branch_imm = '0;

        // Reset held for two edges, then hold cycle, then sequential count.
        tick(); tick();
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_plus1", bus.pc_plus1, 32'd1);
        chk("rst_count", 32'(bus.ras_count), 32'd0);
        chk("rst_ovf", 32'(bus.ras_overflow), 32'd0);
        chk("rst_unf", 32'(bus.ras_underflow), 32'd0);
        reset = 1'b1;
        go(3'd0, 32'd0); chk("hold", bus.pc, 32'd0);
        go(3'd0, 32'd0); chk("seq1", bus.pc, 32'd1);
        go(3'd0, 32'd0); chk("seq2", bus.pc, 32'd2);
        go(3'd0, 32'd0); chk("seq3", bus.pc, 32'd3);

        // Jump-register and branches.
        bus.reg_data = 32'h1234;
        go(3'd1, 32'd0); chk("jreg", bus.pc, 32'h1234);
        go(3'd2, 32'd10); chk("jimm", bus.pc, 32'd10);
        bus.branch_imm = 32'd100; bus.cond = 1'b1;
        go(3'd3, 32'd0); chk("br_taken", bus.pc, 32'd100);
        bus.cond = 1'b0;
        go(3'd3, 32'd0); chk("br_not", bus.pc, 32'd101);

        // Nested call/return.
        bus.reg_data = 32'd77;
        go(3'd2, 32'd5);
        go(3'd5, 32'd200); chk("call1_pc", bus.pc, 32'd200);
        chk("call1_cnt", 32'(bus.ras_count), RAS ? 32'd1 : 32'd0);
        go(3'd5, 32'd300); chk("call2_pc", bus.pc, 32'd300);
        chk("call2_cnt", 32'(bus.ras_count), RAS ? 32'd2 : 32'd0);
        go(3'd6, 32'd0); chk("ret1_pc", bus.pc, RAS ? 32'd201 : 32'd77);
        chk("ret1_cnt", 32'(bus.ras_count), RAS ? 32'd1 : 32'd0);
        go(3'd6, 32'd0); chk("ret2_pc", bus.pc, RAS ? 32'd6 : 32'd77);
        chk("ret2_cnt", 32'(bus.ras_count), 32'd0);

        // Five calls push 1001,2001,2101,2201,2301; the oldest is overwritten.
        go(3'd2, 32'd1000);
        for (int i = 0; i < 5; i++) begin
            go(3'd5, 32'd2000 + 32'(i) * 32'd100);
            chk("ovf_call_pc", bus.pc, 32'd2000 + 32'(i) * 32'd100);
            chk("ovf_call_cnt", 32'(bus.ras_count), RAS ? ((i < 4) ? 32'(i + 1) : 32'd4) : 32'd0);
            chk("ovf_flag", 32'(bus.ras_overflow), (RAS && i == 4) ? 32'd1 : 32'd0);
        end
        bus.reg_data = 32'd55;
        for (int i = 0; i < 4; i++) begin
            go(3'd6, 32'd0);
            chk("ovf_ret_pc", bus.pc, RAS ? (32'd2301 - 32'(i) * 32'd100) : 32'd55);
            chk("ovf_ret_cnt", 32'(bus.ras_count), RAS ? 32'(3 - i) : 32'd0);
        end
        go(3'd6, 32'd0); chk("unf_pc", bus.pc, RAS ? 32'd524 : 32'd55);
        chk("unf_flag", 32'(bus.ras_underflow), RAS ? 32'd1 : 32'd0);
        chk("unf_cnt", 32'(bus.ras_count), 32'd0);
        bus.flags_clr = 1'b1;
        go(3'd0, 32'd0);
        chk("clr_ovf", 32'(bus.ras_overflow), 32'd0);
        chk("clr_unf", 32'(bus.ras_underflow), 32'd0);
        // Clear and a new underflow together: the flag must read 1.
        go(3'd6, 32'd0);
        chk("clr_vs_set", 32'(bus.ras_underflow), RAS ? 32'd1 : 32'd0);
        go(3'd0, 32'd0);
        bus.flags_clr = 1'b0;
        chk("clr_again", 32'(bus.ras_underflow), 32'd0);

        // Stall holds PC and RAS even with a call requested.
        go(3'd5, 32'd400); chk("pre_stall", bus.pc, 32'd400);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            go(3'd5, 32'd900);
            chk("stall_pc", bus.pc, 32'd400);
            chk("stall_cnt", 32'(bus.ras_count), RAS ? 32'd1 : 32'd0);
        end
        bus.stall = 1'b0;

        // Wrap and OS/reserved modes.
        go(3'd2, 32'hFFFF_FFFF); chk("wrap_plus1", bus.pc_plus1, 32'd0);
        go(3'd0, 32'd0); chk("wrap_pc", bus.pc, 32'd0);
        go(3'd4, 32'd0); chk("os_pc", bus.pc, 32'd524);
        go(3'd7, 32'd0); chk("rsvd_pc", bus.pc, 32'd525);

        // Reset in the middle of a call sequence.
        go(3'd5, 32'd600); chk("mid_cnt", 32'(bus.ras_count), RAS ? 32'd2 : 32'd0);
        reset = 1'b0;
        go(3'd5, 32'd700); chk("mid_rst_pc", bus.pc, 32'd0);
        chk("mid_rst_cnt", 32'(bus.ras_count), 32'd0);
        reset = 1'b1;
        go(3'd2, 32'd50); chk("mid_hold", bus.pc, 32'd0);
        go(3'd2, 32'd50); chk("mid_run", bus.pc, 32'd50);
        bus.reg_data = 32'd33;
        go(3'd6, 32'd0); chk("post_rst_pop", bus.pc, RAS ? 32'd524 : 32'd33);
        chk("post_rst_unf", 32'(bus.ras_underflow), RAS ? 32'd1 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
